fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width; matches the attached FIFO's WIDTH.
REQ-002 SHALL have parameter LEN_W, default 8: burst length counter width.
REQ-003 SHALL have port i_clk  input  1: clock; all state updates on rising edge.
REQ-004 SHALL have port i_rstn  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1: burst command strobe, sampled only in IDLE.
REQ-006 SHALL have port i_len  input  LEN_W: number of words in the burst, sampled with i_start.
REQ-007 SHALL have port o_busy  output  1: high in RUN or DRAIN.
REQ-008 SHALL have port o_done  output  1: one-cycle pulse at burst completion.
REQ-009 SHALL have port i_fifo_empty  input  1: empty flag of the source FIFO.
REQ-010 SHALL have port i_fifo_data  input  WIDTH: source FIFO read data, valid combinationally in the same cycle as o_fifo_deq.
REQ-011 SHALL have port o_fifo_deq  output  1: dequeue strobe to the source FIFO.
REQ-012 SHALL have port o_valid  output  1: output stream valid.
REQ-013 SHALL have port o_data  output  WIDTH: output stream data.
REQ-014 SHALL have port o_last  output  1: marks the final word of the burst; qualified by o_valid.
REQ-015 SHALL have port i_ready  input  1: downstream accept; a transfer occurs when o_valid & i_ready.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-017 IDLE: i_start & i_len!=0 -> latch issue_cnt=i_len, go RUN next cycle.
REQ-018 IDLE: i_start & i_len==0 -> stay IDLE, pulse o_done on the next cycle, and issue no dequeue.
REQ-019 i_start SHALL be ignored in RUN and DRAIN.
REQ-020 SHALL hold a 2-entry output buffer (FIFO order, count 0..2); o_valid = (count!=0); o_data/o_last are taken from the head entry.
REQ-021 o_fifo_deq = (state==RUN) & (issue_cnt!=0) & ~i_fifo_empty & (count<2); SHALL have no combinational path from i_ready.
REQ-022 On o_fifo_deq, i_fifo_data SHALL be written into the buffer at the same edge, and issue_cnt SHALL decrement by 1.
REQ-023 Stored last flag = (issue_cnt==1) at the time of dequeue.
REQ-024 Latency: a word dequeued in cycle t SHALL appear at o_data with o_valid no earlier than cycle t+1.
REQ-025 Simultaneous write and pop in one cycle SHALL keep count unchanged and order preserved; with count==1 and i_ready held high, the block SHALL sustain 1 word/cycle.
REQ-026 o_valid/o_data/o_last SHALL stay stable while o_valid & ~i_ready.
REQ-027 RUN -> DRAIN when issue_cnt reaches 0 (same edge as the final dequeue).
REQ-028 DRAIN -> IDLE on the edge where the buffer becomes empty (the last-flagged word transfers); o_done SHALL be high for exactly the following cycle.
REQ-029 FIFO empty mid-burst SHALL stall dequeue without error; the burst resumes when empty deasserts.
REQ-030 A new i_start SHALL be accepted in the cycle o_done is high (state is IDLE).
REQ-031 issue_cnt SHALL never underflow; o_fifo_deq SHALL never assert while i_fifo_empty.

Reset
REQ-032 While i_rstn==0 at a clock edge: state=IDLE, issue_cnt=0, buffer count=0, entries=0.
REQ-033 Reset values: o_busy=0, o_done=0, o_fifo_deq=0, o_valid=0, o_data=0, o_last=0.
REQ-034 Reset mid-burst SHALL abort immediately with no o_done; buffered words are discarded.

Verification
REQ-035 Basic: FIFO preloaded with 0x11,0x22,0x33; i_start, i_len=3, i_ready=1 -> o_fifo_deq high for 3 consecutive cycles, outputs 0x11,0x22,0x33 on consecutive cycles, o_last only with 0x33, single o_done pulse.
REQ-036 Backpressure: i_len=4, i_ready=0 -> exactly 2 dequeues, then o_fifo_deq=0; o_data held at first word; i_ready=1 -> remaining words delivered in order, no loss or duplication.
REQ-037 Starvation: FIFO empty after 1 of 3 words -> o_fifo_deq=0 while empty, o_busy=1; refill -> burst completes with o_last on word 3.
REQ-038 Zero length: i_start with i_len=0 -> no o_fifo_deq, o_valid stays 0, o_done pulses once, o_busy stays 0.
REQ-039 Ignore/back-to-back: i_start pulsed during RUN -> no effect; i_start in the o_done cycle with i_len=2 -> second burst starts and delivers 2 words.
REQ-040 Reset abort: i_rstn=0 mid-burst with 1 word buffered -> next cycle all outputs 0, state IDLE, no o_done.

Source files
------------

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Reads a commanded number of words from a source FIFO and
//               presents them as a valid/ready stream. The final word of each
//               burst is tagged with o_last. A one-cycle o_done pulse follows
//               the transfer of that word. Words pass through a 2-entry
//               registered buffer, so there is no combinational path from
//               i_ready to o_fifo_deq.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_fifo_deq,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    input  logic             i_ready
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_RUN      = 2'd1;
    localparam logic [1:0]       c_DRAIN    = 2'd2;
    localparam logic [LEN_W-1:0] c_LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] c_LEN_ONE  = LEN_W'(1);

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_issue_cnt;
    logic             r_done;

    // Output buffer: entry 0 is the head, entry 1 the tail.
    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic             r_last0;
    logic             r_last1;

    logic w_deq;
    logic w_pop;
    logic w_last_in;

    // Dequeue only while words remain to be issued and the buffer has room.
    // The room test uses the registered count, not i_ready, so no
    // combinational path exists from i_ready to o_fifo_deq.
    assign w_deq     = (r_state == c_RUN) && (r_issue_cnt != c_LEN_ZERO) &&
                       !i_fifo_empty && (r_count < 2'd2);
    assign w_pop     = (r_count != 2'd0) && i_ready;
    assign w_last_in = (r_issue_cnt == c_LEN_ONE);

    assign o_fifo_deq = w_deq;
    assign o_busy     = (r_state != c_IDLE);
    assign o_done     = r_done;
    assign o_valid    = (r_count != 2'd0);
    assign o_data     = r_data0;
    assign o_last     = r_last0;

    // Burst control: command acceptance, issue counting and completion pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= c_IDLE;
            r_issue_cnt <= c_LEN_ZERO;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        if (i_len != c_LEN_ZERO) begin
                            r_issue_cnt <= i_len;
                            r_state     <= c_RUN;
                        end else begin
                            // An empty burst completes immediately.
                            r_done <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    if (w_deq) begin
                        r_issue_cnt <= r_issue_cnt - c_LEN_ONE;
                        if (w_last_in) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    // Nothing is written in DRAIN, so popping the only entry
                    // means the last-flagged word has just transferred.
                    if (w_pop && (r_count == 2'd1)) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Two-entry output buffer with simultaneous write/pop support.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            case ({w_deq, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= i_fifo_data;
                        r_last0 <= w_last_in;
                    end else begin
                        r_data1 <= i_fifo_data;
                        r_last1 <= w_last_in;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_data1 <= '0;
                    r_last1 <= 1'b0;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // A write needs room and a pop needs data, so the count
                    // is exactly one: the new word replaces the departing head.
                    r_data0 <= i_fifo_data;
                    r_last0 <= w_last_in;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader. A behavioural
//               source FIFO feeds the DUT; a stream-level reference model
//               (word order plus burst boundaries) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;

    logic             i_clk = 1'b0;
    logic             i_rstn;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             o_busy;
    logic             o_done;
    logic             i_fifo_empty;
    logic [WIDTH-1:0] i_fifo_data;
    logic             o_fifo_deq;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_last;
    logic             i_ready;

    always #5 i_clk = ~i_clk;

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_start      (i_start),
        .i_len        (i_len),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_deq   (o_fifo_deq),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_last       (o_last),
        .i_ready      (i_ready)
    );

    // Source FIFO: every word ever pushed stays in mem, so mem[k] is also
    // the k-th word the stream is expected to carry.
    logic [WIDTH-1:0] mem [0:1023];
    int wp = 0;
    int rp = 0;

    assign i_fifo_empty = (rp == wp);
    assign i_fifo_data  = mem[rp % 1024];

    always @(posedge i_clk) begin
        if (o_fifo_deq === 1'b1) rp <= rp + 1;
    end

    // Reference model state.
    int n_out     = 0;   // words delivered downstream (or discarded by reset)
    int issue_end = 0;   // FIFO index after the last word of the active burst
    int ends[$];         // end indices of accepted bursts
    bit exp_busy  = 1'b0;
    bit exp_done  = 1'b0;
    int n_done    = 0;
    bit mon_en    = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic bit last_at(input int idx);
        return (ends.size() > 0) && (idx + 1 == ends[0]);
    endfunction

    // Compares the current cycle against the model, then advances the model
    // to the state it predicts for the next cycle.
    task automatic monitor();
        int  outstanding;
        bit  xfer;
        bit  nb;
        bit  nd;
        bit  e_deq;
        outstanding = rp - n_out;
        e_deq = exp_busy && (rp < issue_end) && (wp != rp) && (outstanding < 2);
        chk("busy",  o_busy,     exp_busy);
        chk("done",  o_done,     exp_done);
        chk("valid", o_valid,    outstanding != 0);
        chk("deq",   o_fifo_deq, e_deq);
        if (outstanding != 0) begin
            chk("data", o_data, mem[n_out % 1024]);
            chk("last", o_last, last_at(n_out));
        end
        if (o_done === 1'b1) n_done++;

        xfer = (outstanding != 0) && (i_ready === 1'b1);
        nb   = exp_busy;
        nd   = 1'b0;
        if (!i_rstn) begin
            nb        = 1'b0;
            n_out     = rp + ((o_fifo_deq === 1'b1) ? 1 : 0);
            issue_end = n_out;
            ends.delete();
        end else begin
            if (xfer) begin
                if (last_at(n_out)) begin
                    void'(ends.pop_front());
                    nb = 1'b0;
                    nd = 1'b1;
                end
                n_out++;
            end
            if ((i_start === 1'b1) && !exp_busy) begin
                if (i_len != '0) begin
                    issue_end += int'(i_len);
                    ends.push_back(issue_end);
                    nb = 1'b1;
                end else begin
                    nd = 1'b1;
                end
            end
        end
        exp_busy = nb;
        exp_done = nd;
    endtask

    task automatic cyc();
        @(negedge i_clk);
        if (mon_en) monitor();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        mem[wp % 1024] = v;
        wp++;
    endtask

    task automatic start(input int len);
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        cyc();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((exp_busy || exp_done) && (k < budget)) begin
            cyc();
            k++;
        end
        n_cmp++;
        assert (!(exp_busy || exp_done)) else begin
            n_err++;
            $error("FAIL idle_timeout: observed busy %0b expected idle within %0d cycles", o_busy, budget);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  o_busy,     0);
        chk({tag, "_done"},  o_done,     0);
        chk({tag, "_deq"},   o_fifo_deq, 0);
        chk({tag, "_valid"}, o_valid,    0);
        chk({tag, "_data"},  o_data,     0);
        chk({tag, "_last"},  o_last,     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d0;
        int k;
        int len;
        int pre;
        int left;
        int guard;

        i_rstn  = 1'b0;
        i_start = 1'b0;
        i_len   = '0;
        i_ready = 1'b0;
        repeat (3) cyc();
        chk_all_zero("reset");
        i_rstn = 1'b1;
        mon_en = 1'b1;

        // Basic three-word burst with a ready sink.
        i_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        d0 = n_done;
        start(3);
        wait_idle(50);
        chk("basic_done_cnt", n_done - d0, 1);

        // Backpressure: only two words may be fetched while the sink stalls.
        i_ready = 1'b0;
        base = rp;
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        d0 = n_done;
        start(4);
        repeat (6) cyc();
        chk("bp_two_deq", rp - base, 2);
        chk("bp_hold", o_data, 8'hA0);
        i_ready = 1'b1;
        wait_idle(50);
        chk("bp_done_cnt", n_done - d0, 1);

        // Starvation: FIFO runs dry after the first word.
        base = rp;
        push(8'h51);
        start(3);
        repeat (6) cyc();
        chk("starve_busy", o_busy, 1);
        chk("starve_deq_cnt", rp - base, 1);
        push(8'h52); push(8'h53);
        wait_idle(50);

        // Zero-length command.
        d0 = n_done;
        start(0);
        wait_idle(10);
        chk("zero_done_cnt", n_done - d0, 1);

        // Start ignored while running; start accepted in the done cycle.
        push(8'h61); push(8'h62); push(8'h63);
        d0 = n_done;
        start(3);
        i_start = 1'b1;
        i_len   = 8'd5;
        repeat (2) cyc();
        i_start = 1'b0;
        k = 0;
        while ((o_done !== 1'b1) && (k < 50)) begin
            cyc();
            k++;
        end
        chk("b2b_done_seen", o_done, 1);
        push(8'h64); push(8'h65);
        start(2);
        wait_idle(50);
        chk("b2b_done_cnt", n_done - d0, 2);

        // Randomised bursts with random sink stalls and FIFO refill timing.
        for (int b = 0; b < 25; b++) begin
            len  = $urandom_range(0, 6);
            pre  = $urandom_range(0, len);
            left = len - pre;
            for (int j = 0; j < pre; j++) push(8'($urandom));
            start(len);
            guard = 0;
            while ((exp_busy || exp_done || (left > 0)) && (guard < 200)) begin
                i_ready = (($urandom % 4) != 0);
                i_start = exp_busy && (($urandom % 5) == 0);
                i_len   = LEN_W'($urandom_range(0, 7));
                if ((left > 0) && (($urandom % 2) == 0)) begin
                    push(8'($urandom));
                    left--;
                end
                cyc();
                guard++;
            end
            i_start = 1'b0;
            i_ready = 1'b1;
            wait_idle(50);
        end

        // Reset mid-burst with one word buffered.
        i_ready = 1'b0;
        push(8'h71);
        d0 = n_done;
        start(3);
        repeat (4) cyc();
        chk("abort_buffered", o_valid, 1);
        i_rstn = 1'b0;
        cyc();
        i_rstn = 1'b1;
        chk_all_zero("abort");
        repeat (3) cyc();
        chk("abort_no_done", n_done - d0, 0);
        push(8'h81); push(8'h82);
        i_ready = 1'b1;
        start(2);
        wait_idle(50);
        chk("recover_done_cnt", n_done - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
